// File: rtl/pixel_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_arb_pkg
// Brief    : Shared widths, state encoding, default canvas bounds and a
//            canvas bounds helper for the pixel write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_arb_pkg;

    localparam int c_COORD_W = 9;
    localparam int c_COLOR_W = 15;

    // Arbiter state encoding
    localparam int c_STATE_W = 1;
    typedef logic [c_STATE_W-1:0] state_t;
    localparam state_t c_ST_IDLE  = 1'b0;   // brush/glyph arbitration
    localparam state_t c_ST_CLEAR = 1'b1;   // sweeper owns the port

    // Default canvas rectangle (inclusive) and sweep colour
    localparam logic [c_COORD_W-1:0] c_CANVAS_X0   = 9'd89;
    localparam logic [c_COORD_W-1:0] c_CANVAS_X1   = 9'd228;
    localparam logic [c_COORD_W-1:0] c_CANVAS_Y0   = 9'd33;
    localparam logic [c_COORD_W-1:0] c_CANVAS_Y1   = 9'd228;
    localparam logic [c_COLOR_W-1:0] c_CLEAR_COLOR = 15'h7FFF;

    // True when (x,y) lies inside the inclusive rectangle
    function automatic logic in_rect(
        input logic [c_COORD_W-1:0] x,
        input logic [c_COORD_W-1:0] y,
        input logic [c_COORD_W-1:0] x0,
        input logic [c_COORD_W-1:0] x1,
        input logic [c_COORD_W-1:0] y0,
        input logic [c_COORD_W-1:0] y1
    );
        return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_write_arbiter_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : canvas_sweeper
// Brief    : Row-major x/y walker over the canvas rectangle. i_start parks
//            the walker on (X0,Y0); i_advance steps one pixel; o_last flags
//            the bottom-right pixel.
// Revision : 1.0 - initial release
// ============================================================================
module canvas_sweeper
    import pixel_arb_pkg::*;
#(
    parameter logic [c_COORD_W-1:0] X0 = c_CANVAS_X0,
    parameter logic [c_COORD_W-1:0] X1 = c_CANVAS_X1,
    parameter logic [c_COORD_W-1:0] Y0 = c_CANVAS_Y0,
    parameter logic [c_COORD_W-1:0] Y1 = c_CANVAS_Y1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_advance,
    output logic [c_COORD_W-1:0] o_x,
    output logic [c_COORD_W-1:0] o_y,
    output logic                 o_last
);

    logic [c_COORD_W-1:0] r_x;
    logic [c_COORD_W-1:0] r_y;

    // Step x across the row, wrap to the next row, wrap back after the last row
    always_ff @(posedge clk) begin
        if (rst || i_start) begin
            r_x <= X0;
            r_y <= Y0;
        end else if (i_advance) begin
            if (r_x == X1) begin
                r_x <= X0;
                r_y <= (r_y == Y1) ? Y0 : r_y + 9'd1;
            end else begin
                r_x <= r_x + 9'd1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == X1) && (r_y == Y1);

endmodule
`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_write_arbiter
// Brief    : Shares the VGA adapter pixel-write port between the brush path,
//            the canvas clear sweeper and the glyph renderer. One registered
//            write per clock at most. Optional macro PIXEL_ARB_CLIP_EN drops
//            (but still grants) brush/glyph pixels outside the canvas.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_write_arbiter
    import pixel_arb_pkg::*;
#(
    parameter logic [c_COORD_W-1:0] CANVAS_X0   = c_CANVAS_X0,
    parameter logic [c_COORD_W-1:0] CANVAS_X1   = c_CANVAS_X1,
    parameter logic [c_COORD_W-1:0] CANVAS_Y0   = c_CANVAS_Y0,
    parameter logic [c_COORD_W-1:0] CANVAS_Y1   = c_CANVAS_Y1,
    parameter logic [c_COLOR_W-1:0] CLEAR_COLOR = c_CLEAR_COLOR
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic                 clear_done,
    input  logic                 brush_req,
    input  logic [c_COORD_W-1:0] brush_x,
    input  logic [c_COORD_W-1:0] brush_y,
    input  logic [c_COLOR_W-1:0] brush_color,
    output logic                 brush_gnt,
    input  logic                 glyph_req,
    input  logic [c_COORD_W-1:0] glyph_x,
    input  logic [c_COORD_W-1:0] glyph_y,
    input  logic [c_COLOR_W-1:0] glyph_color,
    output logic                 glyph_gnt,
    output logic [c_COORD_W-1:0] vga_x,
    output logic [c_COORD_W-1:0] vga_y,
    output logic [c_COLOR_W-1:0] vga_color,
    output logic                 vga_plot
);

    state_t               r_state;
    logic                 r_last_glyph;     // 1: glyph won the last grant
    logic [c_COORD_W-1:0] r_vga_x;
    logic [c_COORD_W-1:0] r_vga_y;
    logic [c_COLOR_W-1:0] r_vga_color;
    logic                 r_vga_plot;
    logic                 r_clear_done;

    logic                 w_idle_free;
    logic                 w_brush_gnt;
    logic                 w_glyph_gnt;
    logic                 w_start;
    logic                 w_advance;
    logic                 w_last;
    logic                 w_pass;
    logic [c_COORD_W-1:0] w_sweep_x;
    logic [c_COORD_W-1:0] w_sweep_y;
    logic [c_COORD_W-1:0] w_sel_x;
    logic [c_COORD_W-1:0] w_sel_y;
    logic [c_COLOR_W-1:0] w_sel_color;

    // A clear request takes the cycle it arrives in, so nobody is granted then
    assign w_idle_free = !reset && (r_state == c_ST_IDLE) && !clear_start;
    assign w_brush_gnt = w_idle_free && brush_req && (!glyph_req || r_last_glyph);
    assign w_glyph_gnt = w_idle_free && glyph_req && (!brush_req || !r_last_glyph);
    assign w_start     = (r_state == c_ST_IDLE) && clear_start;
    assign w_advance   = (r_state == c_ST_CLEAR);

    assign w_sel_x     = w_brush_gnt ? brush_x     : glyph_x;
    assign w_sel_y     = w_brush_gnt ? brush_y     : glyph_y;
    assign w_sel_color = w_brush_gnt ? brush_color : glyph_color;

`ifdef PIXEL_ARB_CLIP_EN
    assign w_pass = in_rect(w_sel_x, w_sel_y, CANVAS_X0, CANVAS_X1, CANVAS_Y0, CANVAS_Y1);
`else
    assign w_pass = 1'b1;
`endif

    canvas_sweeper #(
        .X0 (CANVAS_X0),
        .X1 (CANVAS_X1),
        .Y0 (CANVAS_Y0),
        .Y1 (CANVAS_Y1)
    ) u_sweeper (
        .clk       (clock),
        .rst       (reset),
        .i_start   (w_start),
        .i_advance (w_advance),
        .o_x       (w_sweep_x),
        .o_y       (w_sweep_y),
        .o_last    (w_last)
    );

    // Port-ownership FSM, round-robin pointer and registered VGA write
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_last_glyph <= 1'b1;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_color  <= '0;
            r_vga_plot   <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_vga_plot   <= 1'b0;
            r_clear_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_state <= c_ST_CLEAR;
                    end else if (w_brush_gnt || w_glyph_gnt) begin
                        r_last_glyph <= w_glyph_gnt;
                        if (w_pass) begin
                            r_vga_x     <= w_sel_x;
                            r_vga_y     <= w_sel_y;
                            r_vga_color <= w_sel_color;
                            r_vga_plot  <= 1'b1;
                        end
                    end
                end
                c_ST_CLEAR: begin
                    r_vga_x     <= w_sweep_x;
                    r_vga_y     <= w_sweep_y;
                    r_vga_color <= CLEAR_COLOR;
                    r_vga_plot  <= 1'b1;
                    if (w_last) begin
                        r_clear_done <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign clear_busy = (r_state == c_ST_CLEAR);
    assign clear_done = r_clear_done;
    assign brush_gnt  = w_brush_gnt;
    assign glyph_gnt  = w_glyph_gnt;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_color  = r_vga_color;
    assign vga_plot   = r_vga_plot;

endmodule
`default_nettype wire
